mul32_seq_accum: RTL and testbench

MUL32_SEQ_ACCUM -- requirements
Module: mul32_seq_accum

---
 rtl/mul32_seq_accum.sv | 136 +++++++++++++
 tb/tb_mul32_seq_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul32_seq_accum.sv
// Sequential 32x32 unsigned multiplier built from one 16x16 partial product per cycle.
// Define MUL_HIGH_WORD_EN for the full 64-bit product; otherwise only the low 32 bits are kept.
module mul32_seq_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and in_ready/out_valid come straight from registers.
`ifdef MUL_HIGH_WORD_EN
    localparam int ACC_W = 64;
    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;
`else
    localparam int ACC_W = 32;
    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, DONE} state_t;
`endif

    state_t             state;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [ACC_W-1:0]   acc;
    logic [15:0]        pp_a;
    logic [15:0]        pp_b;
    logic [5:0]         shamt;
    logic [31:0]        pp;
    logic [ACC_W-1:0]   pp_w;
    logic [ACC_W-1:0]   acc_next;
    logic [63:0]        acc_next_ext;

    // Select the half-words and weight for the partial product of the current state.
    always_comb begin
        pp_a  = a_q[15:0];
        pp_b  = b_q[15:0];
        shamt = 6'd0;
        case (state)
            PP1: begin
                pp_a  = a_q[31:16];
                shamt = 6'd16;
            end
            PP2: begin
                pp_b  = b_q[31:16];
                shamt = 6'd16;
            end
`ifdef MUL_HIGH_WORD_EN
            PP3: begin
                pp_a  = a_q[31:16];
                pp_b  = b_q[31:16];
                shamt = 6'd32;
            end
`endif
            default: ;
        endcase
    end

    // Bits shifted past the accumulator width are dropped, which gives mod 2^32 in the narrow build.
    assign pp           = pp_a * pp_b;
    assign pp_w         = ACC_W'(pp);
    assign acc_next     = acc + (pp_w << shamt);
    assign acc_next_ext = 64'(acc_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        state    <= PP0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                PP0: begin
                    acc   <= acc_next;
                    state <= PP1;
                end
                PP1: begin
                    acc   <= acc_next;
                    state <= PP2;
                end
`ifdef MUL_HIGH_WORD_EN
                PP2: begin
                    acc   <= acc_next;
                    state <= PP3;
                end
                PP3: begin
                    acc       <= acc_next;
                    y         <= acc_next_ext;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`else
                PP2: begin
                    acc       <= acc_next;
                    y         <= acc_next_ext;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul32_seq_accum.sv
// Bench for mul32_seq_accum: directed and random products checked against plain arithmetic.
// Honours MUL_HIGH_WORD_EN the same way as the design.
module tb_mul32_seq_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
    logic        busy;

`ifdef MUL_HIGH_WORD_EN
    localparam int LAT  = 4;
    localparam bit FULL = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FULL = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          acc_cyc[$];

    mul32_seq_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) got_q.push_back(y);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] z);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, z};
        return FULL ? p : {32'd0, p[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept(input logic [31:0] x, input logic [31:0] z);
        int t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        a        = x;
        b        = z;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.push_back(model(x, z));
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        check("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    endtask

    // Junk in_valid pulses while busy must be ignored.
    task automatic wait_done();
        int edges = 0;
        while (out_valid !== 1'b1 && edges < 10) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            edges++;
            if (out_valid !== 1'b1) check("busy_during_op", {63'd0, busy}, 64'd1);
        end
        in_valid = 1'b0;
        check("latency", 64'(edges), 64'(LAT));
        check("y_at_done", y, exp_q[0]);
    endtask

    task automatic handshake(input int hold);
        logic [63:0] expv;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_y", y, exp_q[0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        expv = exp_q.pop_front();
        check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_hs_busy", {63'd0, busy}, 64'd0);
        check("post_hs_y", y, expv);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] z, input int hold);
        accept(x, z);
        wait_done();
        handshake(hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_y", y, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd3, 32'd5, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 0);
        run_op($urandom, $urandom, 10);
        for (int i = 0; i < 8; i++) run_op($urandom, $urandom, $urandom_range(0, 3));

        // Reset while in PP1 discards the operation.
        begin
            int seen = 0;
            accept(32'hDEAD_BEEF, 32'h1234_5678);
            exp_q.delete();
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
            check("midrst_y", y, 64'd0);
            check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
            check("midrst_busy", {63'd0, busy}, 64'd0);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen++;
            end
            check("midrst_no_out_valid", 64'(seen), 64'd0);
        end

        // Back-to-back with in_valid and out_ready held high.
        begin
            int t = 0;
            acc_cyc.delete();
            got_q.delete();
            exp_q.push_back(model(32'd1, 32'd2));
            exp_q.push_back(model(32'd7, 32'd9));
            mon_en    = 1'b1;
            a         = 32'd1;
            b         = 32'd2;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (acc_cyc.size() < 1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            a = 32'd7;
            b = 32'd9;
            t = 0;
            while (acc_cyc.size() < 2 && t < 20) begin
                @(negedge clk);
                t++;
            end
            in_valid = 1'b0;
            t = 0;
            while (got_q.size() < 2 && t < 20) begin
                @(negedge clk);
                t++;
            end
            out_ready = 1'b0;
            mon_en    = 1'b0;
            check("b2b_accepts", 64'(acc_cyc.size()), 64'd2);
            check("b2b_results", 64'(got_q.size()), 64'd2);
            if (acc_cyc.size() == 2) check("b2b_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(LAT + 2));
            if (got_q.size() == 2) begin
                check("b2b_first", got_q[0], exp_q.pop_front());
                check("b2b_second", got_q[1], exp_q.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
